// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter: FIFO plus back-to-back serialiser
// The line is driven from a flop; popped bytes live in the shift register so the FIFO can refill.
module uart_tx_fifo #(
  parameter int CLK_FREQ_HZ = 10000000,
  parameter int BAUD_RATE   = 1000000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [DATA_BITS-1:0]        i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_overflow,
  input  logic                        i_clr_ovf,
  output logic                        o_uart_tx
);
  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = $clog2(2 * DIV);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        count;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 tx;
  logic                 push, pop, head_par;
  logic [DATA_BITS-1:0] head;

  assign o_ready   = (count != FULL);
  assign o_level   = count;
  assign o_busy    = (state != S_IDLE) || (count != '0);
  assign o_uart_tx = tx;

  assign push     = i_valid && o_ready;
  assign head     = mem[rd_ptr];
  assign head_par = (^head) ^ (PARITY == 2);
  // Pops use the registered count, so a byte pushed into an empty FIFO waits one cycle.
  assign pop      = (count != '0) &&
                    ((state == S_IDLE) || (state == S_STOP && cnt == STOP_END));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped push takes priority over a clear in the same cycle.
      if (i_valid && !o_ready) o_overflow <= 1'b1;
      else if (i_clr_ovf)      o_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg   <= head;
            par_bit <= head_par;
            cnt     <= '0;
            state   <= S_START;
            tx      <= 1'b0;
          end
        end
        S_START: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
            tx      <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              if (PARITY != 0) begin
                state <= S_PARITY;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            state <= S_STOP;
            tx    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == STOP_END) begin
            cnt <= '0;
            if (pop) begin
              shreg   <= head;
              par_bit <= head_par;
              state   <= S_START;
              tx      <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule
